// File: rtl/fp32_pkg.sv
// Shared constants and stage-1 payload type for the binary32 multiply
// normalize/round/pack pipeline.
package fp32_pkg;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   // NAN also covers inf*zero, so stage 2 only sees one special class.
   typedef enum logic [1:0] {
      CLS_NORM = 2'd0,
      CLS_ZERO = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } cls_e;

   typedef struct packed {
      logic               sign;
      logic signed [10:0] exp;
      logic [22:0]        mant;
      logic               g;
      logic               st;
      cls_e               cls;
   } s1_t;
endpackage

// File: rtl/fp32_round_pack.sv
// Combinational stage 2: round-to-nearest-even, range check against the
// binary32 exponent limits (FTZ), special-value select and pack.
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic        sign,
   input  logic [10:0] exp,
   input  logic [22:0] mant,
   input  logic        g,
   input  logic        st,
   input  logic [1:0]  cls,
   output logic [31:0] result,
   output logic [3:0]  flags
);
   localparam logic signed [10:0] EMAX = 11'(EXP_MAX);
   localparam logic signed [10:0] EMIN = 11'sd0;

   logic               rnd;
   logic [23:0]        msum;
   logic signed [10:0] exp_f;
   logic               inexact;

   assign rnd     = g & (st | mant[0]);
   assign msum    = {1'b0, mant} + {23'b0, rnd};
   // Mantissa carry-out leaves msum[22:0]=0, which is already the right fraction.
   assign exp_f   = $signed(exp + {10'b0, msum[23]});
   assign inexact = g | st;

   always_comb begin
      result = '0;
      flags  = '0;
      case (cls_e'(cls))
         CLS_NAN: begin
            result              = QNAN;
            flags[FLG_INVALID]  = 1'b1;
         end
         CLS_INF:  result = PINF | {sign, 31'b0};
         CLS_ZERO: result = {sign, 31'b0};
         default: begin
            if (exp_f >= EMAX) begin
               result               = PINF | {sign, 31'b0};
               flags[FLG_OVERFLOW]  = 1'b1;
               flags[FLG_INEXACT]   = 1'b1;
            end else if (exp_f <= EMIN) begin
               result               = {sign, 31'b0};
               flags[FLG_UNDERFLOW] = 1'b1;
               flags[FLG_INEXACT]   = 1'b1;
            end else begin
               result              = {sign, exp_f[7:0], msum[22:0]};
               flags[FLG_INEXACT]  = inexact;
            end
         end
      endcase
   end
endmodule

// File: rtl/fp32_mul_normround.sv
// Two-stage normalize / round+pack pipeline behind the fp32 mantissa
// multiplier, valid/ready on both sides with no skid buffer.
module fp32_mul_normround
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [47:0] in_prod,
   input  logic        in_zero,
   input  logic        in_inf,
   input  logic        in_nan,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_flags
);
   logic [2:1]  vld_pipe;
   s1_t         s1_d, s1_q;
   logic        s2_adv, accept;
   logic [31:0] rp_result;
   logic [3:0]  rp_flags;

   assign s2_adv    = !vld_pipe[2] | out_ready;
   assign in_ready  = !rst & (!vld_pipe[1] | s2_adv);
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_pipe[2];

   // Normalize: product is in [1,4), so at most one right shift.
   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_sign;
      if (in_prod[47]) begin
         s1_d.mant = in_prod[46:24];
         s1_d.g    = in_prod[23];
         s1_d.st   = |in_prod[22:0];
      end else begin
         s1_d.mant = in_prod[45:23];
         s1_d.g    = in_prod[22];
         s1_d.st   = |in_prod[21:0];
      end
      s1_d.exp = $signed({in_exp[9], in_exp} + {10'b0, in_prod[47]});
      if (in_nan || (in_inf && in_zero)) s1_d.cls = CLS_NAN;
      else if (in_inf)                   s1_d.cls = CLS_INF;
      else if (in_zero)                  s1_d.cls = CLS_ZERO;
      else                               s1_d.cls = CLS_NORM;
   end

   fp32_round_pack u_rp (
      .sign   (s1_q.sign),
      .exp    (s1_q.exp),
      .mant   (s1_q.mant),
      .g      (s1_q.g),
      .st     (s1_q.st),
      .cls    (s1_q.cls),
      .result (rp_result),
      .flags  (rp_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe   <= '0;
         s1_q       <= '0;
         out_result <= '0;
         out_flags  <= '0;
      end else begin
         if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               out_result <= rp_result;
               out_flags  <= rp_flags;
            end
         end
         if (in_ready) vld_pipe[1] <= in_valid;
         if (accept)   s1_q        <= s1_d;
      end
   end
endmodule

// File: tb/tb_fp32_mul_normround.sv
// Scoreboard bench for fp32_mul_normround: directed rounding/range/special
// vectors, backpressure, mid-flight reset and randomized traffic.
module tb_fp32_mul_normround;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
   logic [9:0]  in_exp;
   logic [47:0] in_prod;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int n_cmp = 0;
   int n_bad = 0;
   logic [35:0] sb[$];
   logic        stalled = 1'b0;
   logic [35:0] held;

   always #5 clk = ~clk;

   fp32_mul_normround dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
      .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: integer shift/remainder view of round-to-nearest-even.
   function automatic logic [35:0] model(input logic s, input logic [9:0] e,
                                         input logic [47:0] p, input logic z,
                                         input logic i, input logic n);
      int ex, sh;
      logic [47:0] sig, rem, half;
      logic up;
      if (n || (i && z)) return {4'b1000, 32'h7FC0_0000};
      if (i) return {4'b0000, s, 31'h7F80_0000};
      if (z) return {4'b0000, s, 31'h0};
      ex   = int'($signed(e)) + (p[47] ? 1 : 0);
      sh   = p[47] ? 24 : 23;
      sig  = p >> sh;
      rem  = p & ((48'd1 << sh) - 48'd1);
      half = 48'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && sig[0]);
      sig  = sig + {47'b0, up};
      if (sig[24]) begin
         sig = sig >> 1;
         ex  = ex + 1;
      end
      if (ex >= 255) return {4'b0101, s, 31'h7F80_0000};
      if (ex <= 0)   return {4'b0011, s, 31'h0};
      return {3'b000, rem != 0, s, ex[7:0], sig[22:0]};
   endfunction

   task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                       input logic z, input logic i, input logic n);
      bit ok = 0;
      in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p;
      in_zero = z; in_inf = i; in_nan = n;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("in_ready_timeout", in_ready, 1);
      else begin
         sb.push_back(model(s, e, p, z, i, n));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) stalled = 1'b0;
      else begin
         if (stalled) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", {out_flags, out_result}, held);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
            else chk("result", {out_flags, out_result}, sb.pop_front());
         end
         stalled = out_valid && !out_ready;
         held    = {out_flags, out_result};
      end
   end

   initial begin
      logic [47:0] rp;
      logic [9:0]  re;
      int r;
      rst = 1'b1; in_valid = 0; in_sign = 0; in_exp = 0; in_prod = 0;
      in_zero = 0; in_inf = 0; in_nan = 0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", {out_flags, out_result}, 36'h0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // 1.0 x 1.0 with latency check
      send(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0);
      chk("lat_early", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_2", out_valid, 1);

      send(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);   // 1.5*1.5
      send(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0);   // tie, even -> stay
      send(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0);   // tie, odd -> up
      send(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0);   // mantissa carry
      send(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0);   // overflow
      send(0, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0);   // -5: underflow +0
      send(1, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0);   // underflow -0
      send(0, 10'd127, 48'h4000_0000_0000, 1, 1, 0);   // inf*0
      send(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0);   // -inf
      send(1, 10'd3,   48'h4000_0000_0000, 0, 0, 1);   // nan
      send(1, 10'd3,   48'h4000_0000_0000, 1, 0, 0);   // -0
      repeat (4) @(posedge clk);
      #1;
      chk("const_1x1", model(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0), {4'h0, 32'h3F80_0000});

      // Backpressure: four back-to-back with a blocked sink
      out_ready = 1'b0;
      fork
         begin
            send(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0);
            send(1, 10'd128, 48'h9000_0000_0000, 0, 0, 0);
            send(0, 10'd126, 48'h4000_00C0_0000, 0, 0, 0);
            send(1, 10'd130, 48'h7FFF_FFC0_0000, 0, 0, 0);
         end
         begin
            repeat (3) @(posedge clk);
            #2 chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1 chk("bp_drained", sb.size(), 0);

      // Reset with two results in flight
      out_ready = 1'b0;
      send(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
      send(1, 10'd127, 48'h4000_0000_0000, 0, 0, 0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_result", {out_flags, out_result}, 36'h0);
      rst = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("no_stale", out_valid, 0);
      send(1, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
      chk("rst_lat_early", out_valid, 0);
      @(posedge clk); #1;
      chk("rst_lat_2", out_valid, 1);

      // Randomized traffic with random sink stalls
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               rp = {$urandom, $urandom};
               if ($urandom_range(0, 1) == 1) rp[47] = 1'b1;
               else rp[47:46] = 2'b01;
               re = 10'($urandom_range(0, 320) - 20);
               r  = $urandom_range(0, 11);
               send($urandom_range(0, 1) == 1, re, rp, r == 0 || r == 3, r == 1 || r == 3, r == 2);
            end
         end
         begin
            repeat (150) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
      #1 chk("final_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
